// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// It stalls the pipeline while it iterates. It emits the quotient (LO) and the
// remainder (HI) together with a one-cycle result_valid strobe.
//
// Handshake: start is a level request that is sampled only in IDLE.
// An operation is accepted on a rising edge with start=1 and annul=0.
// div_stall stays high from the accepting cycle through the last iteration.
// result_valid is high for exactly one cycle.
// quotient/remainder are meaningful only while result_valid is high.
// Outside that cycle they hold the previous result.
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              annul,
    output logic              div_stall,
    output logic              result_valid,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvsr;
    logic [DATA_W-1:0] q_hold;
    logic [DATA_W-1:0] r_hold;
    logic              q_neg;
    logic              r_neg;

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    // Operand magnitudes, the restoring trial subtraction and the sign fix-up.
    always_comb begin
        a_mag   = (signed_div && a[DATA_W-1]) ? (~a + 1'b1) : a;
        b_mag   = (signed_div && b[DATA_W-1]) ? (~b + 1'b1) : b;
        shifted = {rem, quo[DATA_W-1]};
        diff    = shifted - {1'b0, dvsr};
        q_fix   = q_neg ? (~quo + 1'b1) : quo;
        r_fix   = r_neg ? (~rem + 1'b1) : rem;
    end

    // Result ports show the fixed-up value in DONE and the held value otherwise.
    always_comb begin
        quotient  = (state == DONE) ? q_fix : q_hold;
        remainder = (state == DONE) ? r_fix : r_hold;
        div_stall = ((state == IDLE) && start && !annul) || (state == BUSY);
        dbg_state = state;
    end

    // Control FSM plus datapath registers, one restoring step per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            quo          <= '0;
            rem          <= '0;
            dvsr         <= '0;
            q_hold       <= '0;
            r_hold       <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_valid <= 1'b0;
                    if (start && !annul) begin
                        cnt  <= '0;
                        dvsr <= b_mag;
                        if (b == '0) begin
                            // Divide by zero: fixed result and no sign fix-up.
                            quo          <= '1;
                            rem          <= a;
                            q_neg        <= 1'b0;
                            r_neg        <= 1'b0;
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end else begin
                            quo   <= a_mag;
                            rem   <= '0;
                            q_neg <= signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
                            r_neg <= signed_div & a[DATA_W-1];
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (annul) begin
                        // A flush abandons the divide; nothing gets written back.
                        state <= IDLE;
                        cnt   <= '0;
                        quo   <= '0;
                        rem   <= '0;
                        dvsr  <= '0;
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                    end else begin
                        if (diff[DATA_W]) begin
                            rem <= shifted[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b0};
                        end else begin
                            rem <= diff[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b1};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    q_hold       <= q_fix;
                    r_hold       <= r_fix;
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit.
// Cycle 0 is the cycle in which start is driven.
// Outputs are sampled on the falling edge of each cycle.
module tb_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_div;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         annul;
    logic         div_stall;
    logic         result_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;

    // Observations recorded by run_ops
    logic         stall_hist[0:127];
    logic [1:0]   state_hist[0:127];
    int           valid_count;
    int           valid_cyc[0:3];
    logic [W-1:0] valid_q[0:3];
    logic [W-1:0] valid_r[0:3];
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;

    div_unit #(.DATA_W(W), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div   (signed_div),
        .a            (a),
        .b            (b),
        .annul        (annul),
        .div_stall    (div_stall),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder),
        .dbg_state    (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: start op1 in cycle 0 and optionally op2 in cycle s2.
    // Assert annul in cycle annul_at. Record ncyc cycles of observations.
    task automatic run_ops(input logic sd1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input int s2, input logic sd2, input logic [W-1:0] a2,
                           input logic [W-1:0] b2, input int annul_at, input int ncyc);
        valid_count = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == s2);
            if (s2 >= 0 && c >= s2) begin
                signed_div = sd2; a = a2; b = b2;
            end else begin
                signed_div = sd1; a = a1; b = b1;
            end
            annul = (c == annul_at);
            @(negedge clk);
            stall_hist[c] = div_stall;
            state_hist[c] = dbg_state;
            if (result_valid) begin
                if (valid_count < 4) begin
                    valid_cyc[valid_count] = c;
                    valid_q[valid_count]   = quotient;
                    valid_r[valid_count]   = remainder;
                end
                valid_count++;
            end
            last_q = quotient;
            last_r = remainder;
        end
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dbg_state !== 2'd0 || result_valid !== 1'b0 || div_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: state=%0d valid=%b stall=%b, expected 0/0/0",
                     dbg_state, result_valid, div_stall);
        end
        checks++;
        if (quotient !== 32'h0 || remainder !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: q=%h r=%h, expected 0/0", quotient, remainder);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        logic stall_ok;
        run_ops(1'b0, 32'd100, 32'd7, -1, 1'b0, '0, '0, -1, 36);
        stall_ok = 1'b1;
        for (int c = 0; c < 36; c++)
            if (stall_hist[c] !== (c <= 32)) stall_ok = 1'b0;
        checks++;
        if (!stall_ok) begin
            failures++;
            $display("FAIL divu_stall: stall pattern wrong, expected 1 in cycles 0-32 only");
        end
        checks++;
        if (valid_count != 1 || valid_cyc[0] != 33) begin
            failures++;
            $display("FAIL divu_latency: count=%0d cycle=%0d, expected 1 at cycle 33",
                     valid_count, valid_cyc[0]);
        end
        checks++;
        if (valid_count < 1 || valid_q[0] !== 32'd14 || valid_r[0] !== 32'd2) begin
            failures++;
            $display("FAIL divu_100_7: q=%h r=%h, expected 0000000e/00000002",
                     valid_q[0], valid_r[0]);
        end
        checks++;
        if (last_q !== 32'd14 || last_r !== 32'd2) begin
            failures++;
            $display("FAIL divu_hold: q=%h r=%h after DONE, expected 0000000e/00000002",
                     last_q, last_r);
        end
    endtask

    task automatic test_signed();
        run_ops(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, '0, '0, -1, 35);
        checks++;
        if (valid_count != 1 || valid_q[0] !== 32'hFFFF_FFFD || valid_r[0] !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_m7_2: count=%0d q=%h r=%h, expected 1 fffffffd/ffffffff",
                     valid_count, valid_q[0], valid_r[0]);
        end
        run_ops(1'b1, 32'd7, 32'hFFFF_FFFE, -1, 1'b0, '0, '0, -1, 35);
        checks++;
        if (valid_count != 1 || valid_q[0] !== 32'hFFFF_FFFD || valid_r[0] !== 32'd1) begin
            failures++;
            $display("FAIL div_7_m2: count=%0d q=%h r=%h, expected 1 fffffffd/00000001",
                     valid_count, valid_q[0], valid_r[0]);
        end
    endtask

    task automatic test_boundaries();
        run_ops(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, '0, '0, -1, 35);
        checks++;
        if (valid_count != 1 || valid_q[0] !== 32'h8000_0000 || valid_r[0] !== 32'h0) begin
            failures++;
            $display("FAIL div_overflow: count=%0d q=%h r=%h, expected 1 80000000/00000000",
                     valid_count, valid_q[0], valid_r[0]);
        end
        run_ops(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 1'b0, '0, '0, -1, 35);
        checks++;
        if (valid_count != 1 || valid_q[0] !== 32'hFFFF_FFFF || valid_r[0] !== 32'h0) begin
            failures++;
            $display("FAIL divu_max_1: count=%0d q=%h r=%h, expected 1 ffffffff/00000000",
                     valid_count, valid_q[0], valid_r[0]);
        end
    endtask

    task automatic test_div_zero();
        run_ops(1'b0, 32'd5, 32'd0, -1, 1'b0, '0, '0, -1, 4);
        checks++;
        if (valid_count != 1 || valid_cyc[0] != 1) begin
            failures++;
            $display("FAIL divz_latency: count=%0d cycle=%0d, expected 1 at cycle 1",
                     valid_count, valid_cyc[0]);
        end
        checks++;
        if (valid_q[0] !== 32'hFFFF_FFFF || valid_r[0] !== 32'd5) begin
            failures++;
            $display("FAIL divz_value: q=%h r=%h, expected ffffffff/00000005",
                     valid_q[0], valid_r[0]);
        end
        checks++;
        if (stall_hist[0] !== 1'b1 || stall_hist[1] !== 1'b0) begin
            failures++;
            $display("FAIL divz_stall: c0=%b c1=%b, expected 1/0", stall_hist[0], stall_hist[1]);
        end
        // Signed divide by zero with a negative dividend: no sign fix-up
        run_ops(1'b1, 32'hFFFF_FFF9, 32'd0, -1, 1'b0, '0, '0, -1, 4);
        checks++;
        if (valid_count != 1 || valid_q[0] !== 32'hFFFF_FFFF || valid_r[0] !== 32'hFFFF_FFF9) begin
            failures++;
            $display("FAIL divz_signed: count=%0d q=%h r=%h, expected 1 ffffffff/fffffff9",
                     valid_count, valid_q[0], valid_r[0]);
        end
    endtask

    task automatic test_annul();
        run_ops(1'b0, 32'd100, 32'd7, -1, 1'b0, '0, '0, 10, 40);
        checks++;
        if (state_hist[11] !== 2'd0 || stall_hist[11] !== 1'b0) begin
            failures++;
            $display("FAIL annul_idle: state=%0d stall=%b in cycle 11, expected 0/0",
                     state_hist[11], stall_hist[11]);
        end
        checks++;
        if (valid_count != 0) begin
            failures++;
            $display("FAIL annul_novalid: result_valid seen %0d times, expected 0", valid_count);
        end
        run_ops(1'b0, 32'd9, 32'd3, -1, 1'b0, '0, '0, -1, 35);
        checks++;
        if (valid_count != 1 || valid_cyc[0] != 33 || valid_q[0] !== 32'd3 || valid_r[0] !== 32'd0) begin
            failures++;
            $display("FAIL annul_next: count=%0d cyc=%0d q=%h r=%h, expected 1 33 00000003/00000000",
                     valid_count, valid_cyc[0], valid_q[0], valid_r[0]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7; annul = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (dbg_state !== 2'd0 || div_stall !== 1'b0 || result_valid !== 1'b0 ||
            quotient !== 32'h0 || remainder !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: state=%0d stall=%b valid=%b q=%h r=%h, expected all 0",
                     dbg_state, div_stall, result_valid, quotient, remainder);
        end
        #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_novalid: result_valid seen %0d times, expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        run_ops(1'b0, 32'd100, 32'd7, 34, 1'b1, 32'hFFFF_FF9C, 32'd7, -1, 70);
        checks++;
        if (valid_count != 2 || valid_cyc[0] != 33 || valid_cyc[1] != 67) begin
            failures++;
            $display("FAIL b2b_timing: count=%0d c0=%0d c1=%0d, expected 2 at 33 and 67",
                     valid_count, valid_cyc[0], valid_cyc[1]);
        end
        checks++;
        if (valid_q[0] !== 32'd14 || valid_r[0] !== 32'd2 ||
            valid_q[1] !== 32'hFFFF_FFF2 || valid_r[1] !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL b2b_values: q0=%h r0=%h q1=%h r1=%h, expected 0000000e/00000002 fffffff2/fffffffe",
                     valid_q[0], valid_r[0], valid_q[1], valid_r[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            valid_cyc[i] = -1; valid_q[i] = '0; valid_r[i] = '0;
        end
        test_reset();
        test_divu_basic();
        test_signed();
        test_boundaries();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage.
- Sits directly downstream of the ALU decoder. It consumes the DIV/DIVU operations that the decoder selects with its HILO_MULT signalling, and produces the quotient (LO) and remainder (HI) for the hi/lo register write.
- Stalls the pipeline while an iteration sequence is running.

Parameters:
- DATA_W, 32, operand/result width; the iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  execute stage holds a DIV/DIVU (ALUCONTROL_DIV or ALUCONTROL_DIVU)
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- a  input  DATA_W  dividend (rs)
- b  input  DATA_W  divisor (rt)
- annul  input  1  flush of the execute stage; abandons the operation
- div_stall  output  1  pipeline freeze request
- result_valid  output  1  one-cycle strobe; hi/lo write enable for the divide
- quotient  output  DATA_W  written to LO
- remainder  output  DATA_W  written to HI

Behaviour:
- States: IDLE, BUSY, DONE. Reset (asynchronous, any state, including mid-operation) forces:
  - state = IDLE
  - counter, working registers and sign flags = 0
  - result_valid = 0, quotient = 0, remainder = 0
- IDLE:
  - On an edge with start=1 and annul=0, latch |a| and |b|. Magnitudes are taken only when signed_div=1; otherwise the raw values are latched.
  - Latch q_neg = signed_div & (a[MSB]^b[MSB]) and r_neg = signed_div & a[MSB].
  - If b == 0, go to DONE with quotient register = all ones and remainder register = a (raw). Sign fix-up is suppressed for this case.
  - Otherwise go to BUSY with counter = 0.
- BUSY:
  - Each edge performs one restoring step: shift {rem, quo} left by 1, trial-subtract the divisor from rem, keep the difference and set quo LSB = 1 if there is no borrow, else keep rem and set LSB = 0. Then counter += 1.
  - On the edge where counter reaches DATA_W-1 (the DATA_W-th step), go to DONE.
  - annul=1 on any BUSY edge: go to IDLE and discard the working registers. No result_valid is produced.
- DONE:
  - result_valid = 1 for exactly this one cycle.
  - quotient = q_neg ? -quo : quo; remainder = r_neg ? -rem : rem. The fix-up is combinational from the stored flags.
  - Next edge: go to IDLE unconditionally. start and annul are ignored in DONE.
- div_stall = (IDLE & start & ~annul) | BUSY. It is combinational so the decode/execute registers freeze in the start cycle. It is 0 in DONE, so the dividing instruction advances with result_valid.
- Latency: start cycle C → result_valid in cycle C+DATA_W+1 (C+33 for DATA_W=32). Divide by zero → C+1.
- Overflow (signed 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. No trap.
- quotient and remainder hold their last value outside DONE. Consumers must qualify on result_valid.
- Back-to-back divides: the second start is seen in IDLE the cycle after DONE, so there is no lost or duplicated operation.

Test Plan:
- DIVU a=100, b=7, start in cycle 0 → div_stall=1 in cycles 0–32; result_valid=1 only in cycle 33; quotient=14, remainder=2.
- DIV a=0xFFFFFFF9 (−7), b=2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). DIV a=7, b=0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- DIV a=0x80000000, b=0xFFFFFFFF → quotient=0x80000000, remainder=0; DIVU a=0xFFFFFFFF, b=1 → quotient=0xFFFFFFFF, remainder=0.
- DIVU a=5, b=0 → result_valid in cycle 1, quotient=0xFFFFFFFF, remainder=5, div_stall low in cycle 1.
- DIVU 100/7 with annul=1 in cycle 10 → state IDLE in cycle 11, div_stall=0, result_valid never asserts. A following DIVU 9/3 yields quotient=3, remainder=0 at its start+33.
- rst pulsed in cycle 15 of a divide (asynchronous, mid-clock) → outputs 0 immediately, IDLE, no result_valid. Two consecutive divides (start re-asserted the cycle after DONE) both produce correct results, 34 cycles apart.
